// File: rtl/ballot_if.sv
// Voter-side signal bundle between the ballot front end and its environment.
interface ballot_if;
  logic        Enable;
  logic        Inhibit;
  logic [14:0] Key;
  logic        Ballot;
  logic [3:0]  IN;
  logic        Ready;
  logic        Error;
  logic        Voted;
  logic        Timeout;
  logic [11:0] Issued;

  modport master (
    output Enable, Inhibit, Key,
    input  Ballot, IN, Ready, Error, Voted, Timeout, Issued
  );

  modport slave (
    input  Enable, Inhibit, Key,
    output Ballot, IN, Ready, Error, Voted, Timeout, Issued
  );
endinterface

// File: rtl/ballot_unit.sv
// Voter key front end: debounces the candidate buttons and turns one accepted key per
// enabled ballot into a registered Ballot pulse with a held candidate code on IN.
module ballot_unit #(
  parameter int unsigned DEB_CYCLES  = 4,
  parameter int unsigned HOLD_CYCLES = 3,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic    clk,
  input  logic    Power,
  ballot_if.slave bus
);
  localparam logic [7:0] DebMin   = 8'(DEB_CYCLES - 1);
  localparam logic [7:0] TmoLast  = 8'(TIMEOUT - 1);
  localparam logic [3:0] HoldLast = 4'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {StIdle, StArmed, StIssue, StHold, StRelease} state_e;

  logic [14:0] key_q, key_d;
  logic [7:0]  stb_q, stb_d;
  logic [4:0]  n_set;
  logic [3:0]  key_code;
  logic        stable, single, multi, released;

  state_e      state_q;
  logic [7:0]  tmo_q;
  logic [3:0]  hold_q;
  logic        rel_q;
  logic        ballot_q, ready_q, error_q, voted_q, timeout_q;
  logic [3:0]  in_q;
  logic [11:0] issued_q;

  // Any change of the raw keys restarts the stability count.
  always_comb begin
    key_d = bus.Key;
    stb_d = '0;
    if (bus.Key == key_q) begin
      key_d = key_q;
      stb_d = (stb_q == 8'hff) ? stb_q : stb_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge Power) begin
    if (Power) begin
      key_q <= '0;
      stb_q <= '0;
    end else begin
      key_q <= key_d;
      stb_q <= stb_d;
    end
  end

  always_comb begin
    n_set    = '0;
    key_code = '0;
    for (int j = 0; j < 15; j++) begin
      if (key_q[j]) begin
        n_set    = n_set + 5'd1;
        key_code = 4'(j + 1);
      end
    end
  end

  assign stable   = (stb_q >= DebMin);
  assign single   = stable && (n_set == 5'd1);
  assign multi    = stable && (n_set > 5'd1);
  assign released = stable && (n_set == 5'd0);

  always_ff @(posedge clk or posedge Power) begin
    if (Power) begin
      state_q   <= StIdle;
      tmo_q     <= '0;
      hold_q    <= '0;
      rel_q     <= 1'b0;
      ballot_q  <= 1'b0;
      in_q      <= '0;
      ready_q   <= 1'b0;
      error_q   <= 1'b0;
      voted_q   <= 1'b0;
      timeout_q <= 1'b0;
      issued_q  <= '0;
    end else begin
      ballot_q  <= 1'b0;
      voted_q   <= 1'b0;
      timeout_q <= 1'b0;
      error_q   <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus.Enable && !bus.Inhibit) begin
            state_q <= StArmed;
            ready_q <= 1'b1;
            tmo_q   <= '0;
            rel_q   <= 1'b0;
          end
        end
        StArmed: begin
          tmo_q <= tmo_q + 8'd1;
          if (bus.Inhibit) begin
            state_q <= StIdle;
            ready_q <= 1'b0;
          end else if (single && rel_q) begin
            // Only a key pressed after a release counts; a key held through Enable never votes.
            state_q  <= StIssue;
            ready_q  <= 1'b0;
            ballot_q <= 1'b1;
            in_q     <= key_code;
            issued_q <= issued_q + 12'd1;
          end else if (tmo_q == TmoLast) begin
            state_q   <= StIdle;
            ready_q   <= 1'b0;
            timeout_q <= 1'b1;
          end else begin
            error_q <= multi;
            if (released) rel_q <= 1'b1;
          end
        end
        StIssue: begin
          state_q <= StHold;
          hold_q  <= '0;
        end
        StHold: begin
          if (hold_q == HoldLast) begin
            state_q <= StRelease;
            in_q    <= '0;
          end else begin
            hold_q <= hold_q + 4'd1;
          end
        end
        StRelease: begin
          if (released) begin
            state_q <= StIdle;
            voted_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.Ballot  = ballot_q;
  assign bus.IN      = in_q;
  assign bus.Ready   = ready_q;
  assign bus.Error   = error_q;
  assign bus.Voted   = voted_q;
  assign bus.Timeout = timeout_q;
  assign bus.Issued  = issued_q;
endmodule

// File: tb/tb_ballot_unit.sv
// Bench for ballot_unit: hand vectors and sequences plus randomized key traffic compared
// every cycle against a behavioural model of the ballot rules.
module tb_ballot_unit;
  localparam int Deb  = 4;
  localparam int Hold = 3;
  localparam int Tmo  = 255;

  logic clk   = 1'b0;
  logic Power = 1'b1;
  always #5 clk = ~clk;

  ballot_if bif ();
  ballot_if tif ();

  assign tif.Enable  = bif.Enable;
  assign tif.Inhibit = bif.Inhibit;
  assign tif.Key     = bif.Key;

  ballot_unit u_dut (
    .clk  (clk),
    .Power(Power),
    .bus  (bif)
  );

  ballot_unit #(
    .TIMEOUT(20)
  ) u_dut_tmo (
    .clk  (clk),
    .Power(Power),
    .bus  (tif)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit mon_en  = 1'b0;

  // ---------------- behavioural model (main DUT, default parameters) ----------------
  typedef enum {MIdle, MArmed, MVoting, MWaitRel} mmode_e;
  mmode_e      m_mode;
  logic [14:0] m_hist[$];  // most recent key samples, newest first
  int          m_age, m_in_left;
  bit          m_seen_rel;
  logic [3:0]  m_code;
  logic [11:0] m_issued;
  bit          e_ballot, e_error, e_voted, e_timeout;

  task automatic model_reset();
    m_hist.delete();
    m_hist.push_front(15'd0);
    m_mode = MIdle; m_age = 0; m_in_left = 0; m_seen_rel = 1'b0;
    m_code = 4'd0; m_issued = 12'd0;
    e_ballot = 1'b0; e_error = 1'b0; e_voted = 1'b0; e_timeout = 1'b0;
  endtask

  task automatic model_edge();
    logic [14:0] pat;
    logic [3:0]  code;
    bit          stable, single, multi, released;
    int          ones;
    pat    = m_hist[0];
    stable = (m_hist.size() == Deb);
    foreach (m_hist[i]) if (m_hist[i] != pat) stable = 1'b0;
    ones = $countones(pat);
    code = 4'd0;
    for (int j = 0; j < 15; j++) if (pat[j]) code = 4'(j + 1);
    single   = stable && ones == 1;
    multi    = stable && ones > 1;
    released = stable && ones == 0;
    e_ballot = 1'b0; e_error = 1'b0; e_voted = 1'b0; e_timeout = 1'b0;
    case (m_mode)
      MIdle: if (bif.Enable && !bif.Inhibit) begin
        m_mode = MArmed; m_age = 0; m_seen_rel = 1'b0;
      end
      MArmed: begin
        if (bif.Inhibit) m_mode = MIdle;
        else if (single && m_seen_rel) begin
          m_mode = MVoting; m_code = code; m_in_left = 1 + Hold;
          e_ballot = 1'b1; m_issued = m_issued + 12'd1;
        end else if (m_age == Tmo - 1) begin
          m_mode = MIdle; e_timeout = 1'b1;
        end else begin
          e_error = multi;
          if (released) m_seen_rel = 1'b1;
        end
        m_age++;
      end
      MVoting: begin
        m_in_left--;
        if (m_in_left == 0) m_mode = MWaitRel;
      end
      MWaitRel: if (released) begin
        m_mode = MIdle; e_voted = 1'b1;
      end
      default: m_mode = MIdle;
    endcase
    m_hist.push_front(bif.Key);
    if (m_hist.size() > Deb) void'(m_hist.pop_back());
  endtask

  always @(posedge clk or posedge Power) begin
    if (Power) model_reset();
    else model_edge();
  end

  function automatic logic [20:0] m_exp();
    return {e_ballot, (m_mode == MVoting) ? m_code : 4'd0, m_mode == MArmed,
            e_error, e_voted, e_timeout, m_issued};
  endfunction

  function automatic logic [20:0] main_out();
    return {bif.Ballot, bif.IN, bif.Ready, bif.Error, bif.Voted, bif.Timeout, bif.Issued};
  endfunction

  function automatic logic [20:0] tmo_out();
    return {tif.Ballot, tif.IN, tif.Ready, tif.Error, tif.Voted, tif.Timeout, tif.Issued};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) if (mon_en && !Power) check("model", main_out(), m_exp());

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_ballot(input string name, input logic [3:0] exp_in);
    int n;
    n = 0;
    while (!bif.Ballot && n < 40) begin cyc(); n++; end
    check(name, {bif.Ballot, bif.IN}, {1'b1, exp_in});
  endtask

  task automatic wait_voted(input string name);
    int n;
    n = 0;
    while (!bif.Voted && n < 40) begin cyc(); n++; end
    check(name, bif.Voted, 1);
  endtask

  task automatic arm();
    bif.Enable = 1'b1;
    cyc();
    bif.Enable = 1'b0;
    cyc();
  endtask

  typedef struct {
    logic        en;
    logic [14:0] key;
    logic [20:0] exp;
  } vec_t;

  function automatic vec_t mk(input logic en, input logic [14:0] key, input logic b,
                              input logic [3:0] in, input logic rdy, input logic v,
                              input logic [11:0] iss);
    vec_t r;
    r.en  = en;
    r.key = key;
    r.exp = {b, in, rdy, 1'b0, v, 1'b0, iss};
    return r;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1);
  end

  initial begin
    vec_t        tbl[18];
    int          r, len;
    logic [14:0] k;

    // Clean vote, candidate 5 (bit 4), defaults
    tbl[0] = mk(1, 15'h0000, 0, 0, 1, 0, 0);
    tbl[1] = mk(0, 15'h0000, 0, 0, 1, 0, 0);
    for (int i = 2; i <= 5; i++) tbl[i] = mk(0, 15'h0010, 0, 0, 1, 0, 0);
    tbl[6] = mk(0, 15'h0010, 1, 5, 0, 0, 1);
    for (int i = 7; i <= 9; i++) tbl[i] = mk(0, 15'h0010, 0, 5, 0, 0, 1);
    tbl[10] = mk(0, 15'h0010, 0, 0, 0, 0, 1);
    tbl[11] = mk(0, 15'h0010, 0, 0, 0, 0, 1);
    for (int i = 12; i <= 15; i++) tbl[i] = mk(0, 15'h0000, 0, 0, 0, 0, 1);
    tbl[16] = mk(0, 15'h0000, 0, 0, 0, 1, 1);
    tbl[17] = mk(0, 15'h0000, 0, 0, 0, 0, 1);

    bif.Enable = 1'b0; bif.Inhibit = 1'b0; bif.Key = 15'd0;
    Power = 1'b1;
    repeat (3) cyc();
    check("reset_main", main_out(), 21'd0);
    check("reset_tmo", tmo_out(), 21'd0);
    Power = 1'b0;
    mon_en = 1'b1;
    repeat (5) cyc();

    foreach (tbl[i]) begin
      bif.Enable = tbl[i].en;
      bif.Key    = tbl[i].key;
      cyc();
      check($sformatf("clean_vote[%0d]", i), main_out(), tbl[i].exp);
    end

    // Inhibit blocks Enable; Enable during HOLD is not queued
    bif.Inhibit = 1'b1; bif.Enable = 1'b1;
    cyc();
    check("inhibit_blocks_enable", bif.Ready, 0);
    bif.Inhibit = 1'b0; bif.Enable = 1'b0;
    cyc();
    arm();
    bif.Key = 15'h0002;
    wait_ballot("hold_vote", 2);
    cyc();
    bif.Enable = 1'b1;
    cyc();
    bif.Enable = 1'b0;
    bif.Key = 15'd0;
    wait_voted("hold_voted");
    cyc();
    check("enable_in_hold_ignored", bif.Ready, 0);

    // Bounce on bit 2
    arm();
    for (int t = 0; t < 12; t++) begin
      bif.Key = ((t / 2) % 2 == 0) ? 15'h0004 : 15'h0000;
      cyc();
      check("bounce_quiet", bif.Ballot, 0);
    end
    bif.Key = 15'h0004;
    wait_ballot("bounce_vote", 3);
    bif.Key = 15'd0;
    wait_voted("bounce_voted");

    // Multi-key, then drop to a single key
    arm();
    bif.Key = 15'h0081;
    repeat (4) cyc();
    check("multi_not_yet", bif.Error, 0);
    cyc();
    check("multi_error", bif.Error, 1);
    repeat (3) begin
      cyc();
      check("multi_hold", {bif.Error, bif.Ballot}, 2'b10);
    end
    bif.Key = 15'h0001;
    repeat (2) cyc();
    check("multi_cleared", bif.Error, 0);
    wait_ballot("multi_drop_vote", 1);
    bif.Key = 15'd0;
    wait_voted("multi_voted");

    // Reset asserted mid-HOLD
    cyc();
    arm();
    bif.Key = 15'h0100;
    wait_ballot("pre_reset_vote", 9);
    cyc();
    Power = 1'b1;
    #1;
    check("reset_mid_hold_main", main_out(), 21'd0);
    check("reset_mid_hold_tmo", tmo_out(), 21'd0);
    bif.Key = 15'd0;
    @(negedge clk);
    cyc();
    Power = 1'b0;

    // Pre-held key never votes; TIMEOUT=20 copy expires, main copy is inhibited
    bif.Key = 15'h0001;
    repeat (6) cyc();
    bif.Enable = 1'b1;
    cyc();
    bif.Enable = 1'b0;
    check("tmo_ready", tif.Ready, 1);
    for (int n = 1; n <= 24; n++) begin
      cyc();
      check($sformatf("tmo_cycle[%0d]", n), {tif.Timeout, tif.Ready, tif.Ballot},
            {n == 20, n < 20, 1'b0});
    end
    check("main_still_armed", {bif.Ready, bif.Ballot}, 2'b10);
    bif.Inhibit = 1'b1;
    cyc();
    bif.Inhibit = 1'b0;
    check("inhibit_abort", {bif.Ready, bif.Ballot, bif.Timeout, bif.Voted}, 4'b0000);
    bif.Key = 15'd0;
    repeat (5) cyc();

    // 4096 ballots wrap the issued counter
    for (int i = 0; i < 4096; i++) begin
      arm();
      bif.Key = 15'(1 << (i % 15));
      wait_ballot("wrap_vote", 4'((i % 15) + 1));
      bif.Key = 15'd0;
      wait_voted("wrap_voted");
    end
    check("issued_wrap", bif.Issued, 0);

    // Randomized traffic against the model
    for (int s = 0; s < 400; s++) begin
      r = $urandom_range(0, 9);
      if (r < 4) k = 15'd0;
      else if (r < 8) k = 15'(1 << $urandom_range(0, 14));
      else k = 15'(1 << $urandom_range(0, 14)) | 15'(1 << $urandom_range(0, 14));
      len = $urandom_range(1, 8);
      bif.Key = k;
      for (int c = 0; c < len; c++) begin
        bif.Enable  = ($urandom_range(0, 3) == 0);
        bif.Inhibit = ($urandom_range(0, 29) == 0);
        cyc();
      end
    end
    bif.Enable = 1'b0; bif.Inhibit = 1'b0; bif.Key = 15'd0;
    repeat (2) cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
